// File: rtl/bioee_framer_pkg.sv
// bioee_framer_pkg: shared framer state type and constants (CSUM state only with ADC_FRAMER_CHECKSUM_EN)
package bioee_framer_pkg;
  localparam int SEQ_W = 12;
  localparam int CHAN_W = 4;
  localparam logic [15:0] HEADER_DEFAULT = 16'hA5C3;
`ifdef ADC_FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA} state_t;
`endif
endpackage

// File: rtl/adc_framer_fifo.sv
// adc_framer_fifo: show-ahead 16-bit sync FIFO with flush; a write into a full FIFO succeeds when a pop frees the slot on the same edge
module adc_framer_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] din,
  input  logic        rd_en,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  always_comb begin
    empty = wp == rp;
    full = wp == {~rp[AW], rp[AW-1:0]};
    re = rd_en && !empty;
    we = wr_en && (!full || re);
    dout = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(we);
      rp <= rp + (AW+1)'(re);
    end
  always_ff @(posedge clk)
    if (we) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/adc_sample_framer.sv
// adc_sample_framer: frames ADC samples as header, {chan,seq}, FRAME_LEN samples; ADC_FRAMER_CHECKSUM_EN appends an XOR trailer word
module adc_sample_framer
  import bioee_framer_pkg::*;
#(
  parameter int          FRAME_LEN   = 256,
  parameter logic [15:0] HEADER_WORD = HEADER_DEFAULT,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CHAN_W-1:0] chan_sel,
  input  logic [15:0]       in_data,
  input  logic              in_valid,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              overflow,
  input  logic              overflow_clr
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  state_t state;
  logic [SEQ_W-1:0] seq;
  logic [CW-1:0] cnt;
  logic [15:0] dout;
  logic last, xfer, can_load, pop, wr, full, empty;
`ifdef ADC_FRAMER_CHECKSUM_EN
  logic [15:0] csum;
`endif
  always_comb begin
    xfer = out_valid && out_ready;
    can_load = !out_valid || out_ready;
    pop = !empty && !last && ((state == SEQ && xfer) || (state == DATA && can_load));
    wr = in_valid && state != IDLE;
  end
  adc_framer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(state == IDLE),
    .wr_en(wr),
    .din(in_data),
    .rd_en(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      seq <= '0;
      cnt <= '0;
      last <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      frame_start <= 1'b0;
      overflow <= 1'b0;
`ifdef ADC_FRAMER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      frame_start <= state == HDR && xfer;
      overflow <= (wr && full && !pop) || (overflow && !overflow_clr);
      if (pop) begin
        out_data <= dout;
        out_valid <= 1'b1;
        cnt <= cnt + 1'b1;
        last <= cnt == LAST;
`ifdef ADC_FRAMER_CHECKSUM_EN
        csum <= csum ^ dout;
`endif
      end
      case (state)
        IDLE: begin
          seq <= '0;
          if (enable) begin
            state <= HDR;
            out_data <= HEADER_WORD;
            out_valid <= 1'b1;
          end
        end
        HDR: begin
          cnt <= '0;
`ifdef ADC_FRAMER_CHECKSUM_EN
          csum <= '0;
`endif
          if (xfer) begin
            state <= SEQ;
            out_data <= {chan_sel, seq};
          end
        end
        SEQ: if (xfer) begin
          seq <= seq + 1'b1;
          state <= DATA;
          if (!pop) out_valid <= 1'b0;
        end
        DATA: if (xfer && last) begin
          last <= 1'b0;
`ifdef ADC_FRAMER_CHECKSUM_EN
          state <= CSUM;
          out_data <= csum;
`else
          state <= enable ? HDR : IDLE;
          out_valid <= enable;
          out_data <= HEADER_WORD;
`endif
        end else if (xfer && !pop) out_valid <= 1'b0;
`ifdef ADC_FRAMER_CHECKSUM_EN
        CSUM: if (xfer) begin
          state <= enable ? HDR : IDLE;
          out_valid <= enable;
          out_data <= HEADER_WORD;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_sample_framer.sv
// tb_adc_sample_framer: directed and randomized frame checks against a word-stream reference model
module tb_adc_sample_framer;
  localparam int FL = 4;
`ifdef ADC_FRAMER_CHECKSUM_EN
  localparam int FT = FL + 3;
`else
  localparam int FT = FL + 2;
`endif
  logic clk = 1'b0;
  logic rst_n, enable, in_valid, out_valid, out_ready, frame_start, overflow, overflow_clr;
  logic [3:0] chan_sel;
  logic [15:0] in_data, out_data;
  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  int pos, hdr_cnt = 0, wraps = 0, n, tgt;
  logic [11:0] mseq;
  logic [3:0] mchan;
  logic [15:0] mx, want, hold_data;
  logic midle, fs_prev, hold_prev, mkeep, avail;
  adc_sample_framer #(.FRAME_LEN(FL), .HEADER_WORD(16'hA5C3), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .chan_sel(chan_sel),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_start(frame_start),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic k);
    in_valid = 1'b1;
    in_data = d;
    mkeep = k;
    tick();
    in_valid = 1'b0;
    mkeep = 1'b1;
  endtask
  task automatic rnd_cycle();
    out_ready = $urandom_range(0, 9) < 8;
    chan_sel = 4'($urandom);
    in_valid = q.size() < 4 && $urandom_range(0, 3) != 0;
    in_data = 16'($urandom);
    mkeep = 1'b1;
    tick();
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pos = 0;
      mseq = '0;
      mx = '0;
      midle = 1'b1;
      fs_prev = 1'b0;
      hold_prev = 1'b0;
    end else begin
      check("frame_start", frame_start, fs_prev);
      if (hold_prev) check("hold", {out_valid, out_data}, {1'b1, hold_data});
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      fs_prev = 1'b0;
      if (in_valid && mkeep && !midle) q.push_back(in_data);
      if (out_valid && out_ready) begin
        if (pos == 0) begin
          want = 16'hA5C3;
          mchan = chan_sel;
          mx = '0;
          fs_prev = 1'b1;
          hdr_cnt++;
        end else if (pos == 1) begin
          want = {mchan, mseq};
          if (mseq == 12'hFFF) wraps++;
          mseq = mseq + 1'b1;
        end else if (pos < FL + 2) begin
          avail = q.size() != 0;
          check("data_avail", avail, 1);
          want = avail ? q.pop_front() : 16'h0000;
          mx = mx ^ want;
        end else want = mx;
        check("word", out_data, want);
        pos++;
        if (pos == FT) begin
          pos = 0;
          if (!enable) begin
            midle = 1'b1;
            q.delete();
            mseq = '0;
          end
        end
      end
      if (midle && enable) midle = 1'b0;
    end
  end
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    chan_sel = '0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    overflow_clr = 1'b0;
    mkeep = 1'b1;
    repeat (3) tick();
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();
    check("idle_no_output", out_valid, 0);
    enable = 1'b1;
    chan_sel = 4'h5;
    out_ready = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) send(16'h0011 * 16'(i), 1'b1);
    n = 0;
    while (!(hdr_cnt == 2 && pos == 2) && n < 100) begin tick(); n++; end
    check("frame2_seq_reached", n < 100, 1);
    send(16'h0055, 1'b1);
    check("latency_edge1", out_valid, 0);
    tick();
    check("latency_edge2", out_valid, 1);
    check("latency_data", out_data, 16'h0055);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i % 3 == 1;
      in_data = 16'h0066 + 16'h0011 * 16'(i / 3);
      tick();
    end
    in_valid = 1'b0;
    check("bp_no_overflow", overflow, 0);
    out_ready = 1'b1;
    n = 0;
    while (!(hdr_cnt == 2 && pos == 0) && n < 100) begin tick(); n++; end
    check("frame2_done", n < 100, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i), i < 4);
    check("ovf_set", overflow, 1);
    overflow_clr = 1'b1;
    send(16'h0200, 1'b0);
    overflow_clr = 1'b0;
    check("ovf_set_beats_clr", overflow, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    out_ready = 1'b1;
    n = 0;
    while (hdr_cnt < 4100 && n < 60000) begin rnd_cycle(); n++; end
    check("random_frames_done", hdr_cnt >= 4100, 1);
    check("random_no_overflow", overflow, 0);
    check("seq_wrapped", wraps >= 1, 1);
    n = 0;
    while (pos != 4 && n < 200) begin rnd_cycle(); n++; end
    check("reach_sample2", pos, 4);
    enable = 1'b0;
    n = 0;
    while (!midle && n < 200) begin rnd_cycle(); n++; end
    check("went_idle", midle, 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 16'($urandom);
      tick();
      check("idle_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("idle_no_overflow", overflow, 0);
    enable = 1'b1;
    tgt = hdr_cnt + 2;
    n = 0;
    while (hdr_cnt < tgt && n < 500) begin rnd_cycle(); n++; end
    check("reenable_frames", hdr_cnt >= tgt, 1);
    n = 0;
    while (pos != 3 && n < 200) begin rnd_cycle(); n++; end
    check("reach_mid_data", pos, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    tgt = hdr_cnt + 2;
    n = 0;
    while (hdr_cnt < tgt && n < 500) begin rnd_cycle(); n++; end
    check("post_reset_frames", hdr_cnt >= tgt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
